seq_rr_dffe_arbiter: RTL

// - Shares one WIDTH-bit enable-register (q <= d when en) between NREQ requesters.
// - Picks one requester per cycle by round-robin; the grant drives the register enable and the write-data mux.
// - An optional lock lets the winner hold exclusive ownership for a multi-cycle burst.
// - Sits between requesting blocks and a shared configuration/status register.
//

---
 rtl/seq_arb_pkg.sv | 15 +
 rtl/comb_rr_prio_enc.sv | 37 +++
 rtl/seq_rr_dffe_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/seq_arb_pkg.sv
// Shared types and helpers for the sequential round-robin arbiters.
//   arb_state_e : arbitration FSM states (free arbitration vs. locked burst)
//   rr_next     : round-robin successor of an index, wrapping mod n (n need not be a power of 2)
package seq_arb_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/comb_rr_prio_enc.sv
// Combinational rotate-priority encoder.
// Grants the first set request found scanning ptr_i, ptr_i+1, ... wrapping mod NREQ.
//   req_i : request vector
//   ptr_i : index with highest priority this cycle (must be < NREQ)
//   gnt_o : one-hot grant, or zero when no request is set
module comb_rr_prio_enc #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o
);

  logic        found;
  int unsigned idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      // Subtraction instead of modulo: ptr_i < NREQ, so one wrap suffices.
      idx = 32'(ptr_i) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!found && (j == idx) && req_i[j]) begin
          gnt_o[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seq_rr_dffe_arbiter.sv
// Round-robin arbiter in front of one shared enable register (q <= d when en).
// A winner may assert lock to keep exclusive ownership for a multi-cycle burst.
//   clk     : clock, rising edge
//   reset   : asynchronous active-high reset
//   req     : per-requester write request
//   lock    : per-requester lock request, only meaningful together with req
//   wdata   : write data, requester i owns bits [i*WIDTH +: WIDTH]
//   gnt     : combinational one-hot (or zero) grant; gnt[i] = write accepted this cycle
//   q       : shared register contents
//   q_owner : index of the requester that last wrote q
//   locked  : high while a burst lock is held
module seq_rr_dffe_arbiter
  import seq_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic [IdxW-1:0]       q_owner,
  output logic                  locked
);

  arb_state_e       state_q, state_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [IdxW-1:0]  lock_id_q, lock_id_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [IdxW-1:0]  owner_q, owner_d;

  logic [NREQ-1:0]  rr_gnt;
  logic [NREQ-1:0]  lock_sel;
  logic [IdxW-1:0]  win_idx;
  logic [WIDTH-1:0] wsel;
  logic             we;
  logic             win_lock;

  comb_rr_prio_enc #(
    .NREQ (NREQ)
  ) u_prio_enc (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt)
  );

  // Grant: free round-robin in ARB, only the lock holder while LOCKED.
  always_comb begin
    lock_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      lock_sel[i] = (IdxW'(i) == lock_id_q);
    end
    gnt = '0;
    if (state_q == ARB) begin
      gnt = rr_gnt;
    end else begin
      gnt = lock_sel & req;
    end
  end

  // AND-OR write mux keyed by the one-hot grant, so X on a non-granted
  // requester's wdata never reaches q.
  always_comb begin
    win_idx = '0;
    wsel    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_idx = IdxW'(i);
      end
      wsel = wsel | (wdata[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
    end
  end

  assign we       = |gnt;
  assign win_lock = |(gnt & lock);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_id_d = lock_id_q;
    q_d       = q_q;
    owner_d   = owner_q;

    if (we) begin
      q_d     = wsel;
      owner_d = win_idx;
    end

    unique case (state_q)
      ARB: begin
        if (we) begin
          if (win_lock) begin
            // Pointer is left alone so the burst does not count as a turn yet.
            state_d   = LOCKED;
            lock_id_d = win_idx;
          end else begin
            ptr_d = IdxW'(rr_next(32'(win_idx), NREQ));
          end
        end
      end
      LOCKED: begin
        // Final beat (req without lock) and abort (no req) both release the lock.
        if (!(we && win_lock)) begin
          state_d = ARB;
          ptr_d   = IdxW'(rr_next(32'(lock_id_q), NREQ));
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ARB;
      ptr_q     <= '0;
      lock_id_q <= '0;
      q_q       <= '0;
      owner_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_id_q <= lock_id_d;
      q_q       <= q_d;
      owner_q   <= owner_d;
    end
  end

  assign q       = q_q;
  assign q_owner = owner_q;
  assign locked  = (state_q == LOCKED);

endmodule
